// File: rtl/spi_port_bridge.sv
// Mode-0 SPI slave turning 24-bit frames into one-cycle read/write strobes for 16-bit ports.
// All SPI pins oversampled in clk; strobes land one clk after the synchronized edge event, no backpressure.
module spi_port_bridge #(
  parameter int NPORTS = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   sck,
  input  logic                   csb,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  output logic [NPORTS-1:0]      read,
  output logic [NPORTS-1:0]      write,
  output logic [15:0]            wdata,
  input  logic [16*NPORTS-1:0]   rdata
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sck_sync_q, sck_sync_d;
  logic [1:0]          csb_sync_q, csb_sync_d;
  logic [1:0]          mosi_sync_q, mosi_sync_d;
  logic                armed_q, armed_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [15:0]         shift_q, shift_d;
  logic [15:0]         tx_q, tx_d;
  logic [1:0]          ld_q, ld_d;
  logic                miso_q, miso_d;
  logic                miso_oe_q, miso_oe_d;
  logic [NPORTS-1:0]   read_q, read_d;
  logic [NPORTS-1:0]   write_q, write_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rd_slice;

  logic csb_s, mosi_s, sck_rise, sck_fall;

  assign csb_s    = csb_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];

  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign read    = read_q;
  assign write   = write_q;
  assign wdata   = wdata_q;

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (cmd_q[6:0] == 7'(i)) rd_slice = rdata[16*i +: 16];
    end
  end

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], sck};
    csb_sync_d  = {csb_sync_q[0], csb};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    // A frame may only start once csb has been seen high since reset.
    armed_d     = armed_q | csb_s;
    miso_oe_d   = armed_q & ~csb_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ld_d        = {ld_q[0], 1'b0};
    miso_d      = miso_q;
    read_d      = '0;
    write_d     = '0;
    wdata_d     = wdata_q;

    if (csb_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      cmd_d     = '0;
      shift_d   = '0;
      tx_d      = '0;
      ld_d      = '0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (armed_q) state_d = CMD;
        CMD: if (sck_rise) begin
          cmd_d     = {cmd_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            state_d = DATA;
            if (cmd_d[7]) begin
              ld_d[0] = 1'b1;
              for (int i = 0; i < NPORTS; i++) begin
                if (cmd_d[6:0] == 7'(i)) read_d[i] = 1'b1;
              end
            end
          end
        end
        DATA: if (sck_rise) begin
          shift_d   = {shift_q[14:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            state_d = DONE;
            if (!cmd_q[7]) begin
              for (int i = 0; i < NPORTS; i++) begin
                if (cmd_q[6:0] == 7'(i)) begin
                  write_d[i] = 1'b1;
                  wdata_d    = shift_d;
                end
              end
            end
          end
        end
        default: ;
      endcase

      // Capture happens the cycle after the read strobe, well before the 8th fall.
      if (ld_q[1]) begin
        tx_d = rd_slice;
      end else if (sck_fall && (state_q == DATA || state_q == DONE)) begin
        miso_d = tx_q[15];
        tx_d   = {tx_q[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      csb_sync_q  <= '0;
      mosi_sync_q <= '0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ld_q        <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      read_q      <= '0;
      write_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      csb_sync_q  <= csb_sync_d;
      mosi_sync_q <= mosi_sync_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ld_q        <= ld_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      read_q      <= read_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_spi_port_bridge.sv
// Directed bench for spi_port_bridge: SPI host model plus a register-array port model.
module tb_spi_port_bridge;
  localparam int NP   = 8;
  localparam int HALF = 6;

  logic              clk = 1'b0;
  logic              rstb, sck, csb, mosi;
  logic              miso, miso_oe;
  logic [NP-1:0]     read, write;
  logic [15:0]       wdata;
  logic [16*NP-1:0]  rdata;

  logic [15:0] port_mem [NP];
  logic        set_en;
  int          set_idx;
  logic [15:0] set_val;

  int          rd_tot, wr_tot, multi_tot;
  logic [NP-1:0] last_read, last_write;
  int          nchecks, nerr, oe_low;
  int          rd0, wr0;
  logic [23:0] rx;

  spi_port_bridge #(.NPORTS(NP)) dut (
    .clk(clk), .rstb(rstb), .sck(sck), .csb(csb), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .read(read), .write(write),
    .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Ports latch wdata on their write strobe; the bench can also preload them.
  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (write[i]) port_mem[i] <= wdata;
      else if (set_en && set_idx == i) port_mem[i] <= set_val;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NP; i++) rdata[16*i +: 16] = port_mem[i];
  end

  initial begin
    rd_tot = 0; wr_tot = 0; multi_tot = 0;
    last_read = '0; last_write = '0;
  end

  always @(negedge clk) begin
    if (|read)  begin rd_tot <= rd_tot + 1; last_read  <= read;  end
    if (|write) begin wr_tot <= wr_tot + 1; last_write <= write; end
    if ($countones(read | write) > 1) multi_tot <= multi_tot + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int idx, input logic [15:0] val);
    @(negedge clk);
    set_idx = idx; set_val = val; set_en = 1'b1;
    @(negedge clk);
    set_en = 1'b0;
  endtask

  task automatic spi_frame(input logic [23:0] frame, input int nbits, input bit keep_cs,
                           input int gap, output logic [23:0] rxd);
    logic [23:0] f;
    f   = frame;
    rxd = '0;
    oe_low = 0;
    @(negedge clk);
    csb = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      mosi = f[23-b];
      repeat (HALF) @(negedge clk);
      rxd[23-b] = miso;
      if (!miso_oe) oe_low++;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (!keep_cs) begin
      csb = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic mark();
    @(negedge clk);
    rd0 = rd_tot; wr0 = wr_tot;
  endtask

  initial begin
    nchecks = 0; nerr = 0;
    rstb = 1'b0; sck = 1'b0; csb = 1'b1; mosi = 1'b0;
    set_en = 1'b0; set_idx = 0; set_val = '0;
    repeat (4) @(negedge clk);
    check("rst_read", read, 8'h00);
    check("rst_write", write, 8'h00);
    check("rst_wdata", wdata, 16'h0000);
    check("rst_miso", miso, 1'b0);
    check("rst_oe", miso_oe, 1'b0);
    rstb = 1'b1;
    for (int i = 0; i < NP; i++) set_port(i, 16'h0000);
    repeat (6) @(negedge clk);

    // single write
    mark();
    spi_frame({1'b0, 7'd3, 16'hA5C3}, 24, 1'b0, 8, rx);
    check("wr_count", wr_tot - wr0, 1);
    check("wr_onehot", last_write, 8'b0000_1000);
    check("wr_data", wdata, 16'hA5C3);
    check("wr_no_read", rd_tot - rd0, 0);

    // single read
    set_port(1, 16'h1234);
    mark();
    spi_frame({1'b1, 7'd1, 16'h0000}, 24, 1'b0, 8, rx);
    check("rd_data", rx[15:0], 16'h1234);
    check("rd_cmd_miso0", rx[23:16], 8'h00);
    check("rd_count", rd_tot - rd0, 1);
    check("rd_onehot", last_read, 8'b0000_0010);
    check("rd_no_write", wr_tot - wr0, 0);
    check("rd_oe", oe_low, 0);

    // aborted write, then full write to the same port
    mark();
    spi_frame({1'b0, 7'd2, 16'hFFFF}, 12, 1'b0, 8, rx);
    check("abort_no_wr", wr_tot - wr0, 0);
    check("abort_wdata", wdata, 16'hA5C3);
    mark();
    spi_frame({1'b0, 7'd2, 16'h0F0F}, 24, 1'b0, 8, rx);
    check("rewr_count", wr_tot - wr0, 1);
    check("rewr_onehot", last_write, 8'b0000_0100);
    check("rewr_data", wdata, 16'h0F0F);

    // out-of-range address
    set_port(0, 16'hFFFF);
    set_port(7, 16'hFFFF);
    mark();
    spi_frame({1'b0, 7'h7F, 16'h1111}, 24, 1'b0, 8, rx);
    check("oor_no_wr", wr_tot - wr0, 0);
    check("oor_wdata", wdata, 16'h0F0F);
    mark();
    spi_frame({1'b1, 7'h7F, 16'h0000}, 24, 1'b0, 8, rx);
    check("oor_no_rd", rd_tot - rd0, 0);
    check("oor_rdata", rx[15:0], 16'h0000);
    check("oor_no_wr2", wr_tot - wr0, 0);

    // reset mid-frame; csb stays low across release so that frame must be ignored
    spi_frame({1'b0, 7'd4, 16'h5555}, 10, 1'b1, 0, rx);
    rstb = 1'b0;
    #1;
    check("mrst_wdata", wdata, 16'h0000);
    check("mrst_oe", miso_oe, 1'b0);
    check("mrst_miso", miso, 1'b0);
    check("mrst_read", read, 8'h00);
    check("mrst_write", write, 8'h00);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    mark();
    spi_frame({1'b0, 7'd0, 16'hDEAD}, 24, 1'b0, 8, rx);
    check("ign_no_wr", wr_tot - wr0, 0);
    check("ign_wdata", wdata, 16'h0000);
    set_port(0, 16'hBEEF);
    mark();
    spi_frame({1'b1, 7'd0, 16'h0000}, 24, 1'b0, 8, rx);
    check("post_rst_data", rx[15:0], 16'hBEEF);
    check("post_rst_count", rd_tot - rd0, 1);
    check("post_rst_onehot", last_read, 8'b0000_0001);

    // back-to-back write then read-back with minimum csb high time
    set_port(5, 16'h0000);
    mark();
    spi_frame({1'b0, 7'd5, 16'h0001}, 24, 1'b0, 4, rx);
    spi_frame({1'b1, 7'd5, 16'h0000}, 24, 1'b0, 8, rx);
    check("b2b_wr_count", wr_tot - wr0, 1);
    check("b2b_rd_count", rd_tot - rd0, 1);
    check("b2b_wr_onehot", last_write, 8'b0010_0000);
    check("b2b_rd_onehot", last_read, 8'b0010_0000);
    check("b2b_data", rx[15:0], 16'h0001);

    check("strobe_exclusive", multi_tot, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
